// File: rtl/pkt_cache_wr.sv
// pkt_cache_wr: write-side controller for the 16-slot packet data cache.
// Writes one packet per granted slot, reports keep/drop at end of packet and
// emits a {ID, word_count} descriptor for kept packets.
// Optional feature macro: PKT_CACHE_WR_DROP_EN (drop overlong packets instead
// of truncating them; also enables the drop counter).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a slot base address from the address manager
// S_READY   | slot held, out_pkt_ready high, waiting for a head word
// S_RECV    | writing packet words into the slot until the tail
// S_DONE    | keep/drop report cycle; drops return straight to idle
// S_WAIT_ID | capturing the slot ID and issuing the descriptor
module pkt_cache_wr #(
   parameter int MAX_WORDS = 128
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [133:0] in_pkt_data,
   input  logic         in_pkt_data_wr,
   output logic         out_pkt_ready,
   input  logic [10:0]  in_waddr,
   input  logic         in_waddr_wr,
   output logic         out_valid,
   output logic         out_valid_wr,
   input  logic [7:0]   in_ID,
   output logic [133:0] out_ram_wdata,
   output logic [10:0]  out_ram_waddr,
   output logic         out_ram_wr,
   output logic [15:0]  out_desc,
   output logic         out_desc_wr,
   output logic [15:0]  out_drop_cnt
);

   localparam logic [1:0] FLAG_HEAD = 2'b01;
   localparam logic [1:0] FLAG_TAIL = 2'b10;
   localparam logic [7:0] MAX_CNT   = 8'(MAX_WORDS);

`ifdef PKT_CACHE_WR_DROP_EN
   localparam logic DROP_EN = 1'b1;
`else
   localparam logic DROP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_READY,
      S_RECV,
      S_DONE,
      S_WAIT_ID
   } state_t;

   state_t      state;
   logic [3:0]  base;   // slot number only; the in-slot offset bits of the grant are always 0
   logic [7:0]  cnt;    // words accepted into the slot so far, saturates at MAX_WORDS
   logic        ovf;    // packet has run past the end of the slot

   logic        unused_waddr;
   assign unused_waddr = ^in_waddr[6:0];

   // Main sequencer: slot capture, packet writes, end-of-packet report and descriptor.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         base          <= '0;
         cnt           <= '0;
         ovf           <= 1'b0;
         out_pkt_ready <= 1'b0;
         out_valid     <= 1'b0;
         out_valid_wr  <= 1'b0;
         out_ram_wdata <= '0;
         out_ram_waddr <= '0;
         out_ram_wr    <= 1'b0;
         out_desc      <= '0;
         out_desc_wr   <= 1'b0;
      end else begin
         out_ram_wr   <= 1'b0;
         out_valid_wr <= 1'b0;
         out_desc_wr  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_waddr_wr) begin
                  base          <= in_waddr[10:7];
                  out_pkt_ready <= 1'b1;
                  state         <= S_READY;
               end
            end
            S_READY: begin
               if (in_pkt_data_wr && in_pkt_data[133:132] == FLAG_HEAD) begin
                  out_ram_wr    <= 1'b1;
                  out_ram_waddr <= {base, 7'd0};
                  out_ram_wdata <= in_pkt_data;
                  cnt           <= 8'd1;
                  ovf           <= 1'b0;
                  out_pkt_ready <= 1'b0;
                  state         <= S_RECV;
               end
            end
            S_RECV: begin
               if (in_pkt_data_wr) begin
                  if (cnt < MAX_CNT) begin
                     out_ram_wr    <= 1'b1;
                     out_ram_waddr <= {base, cnt[6:0]};
                     out_ram_wdata <= in_pkt_data;
                     cnt           <= cnt + 8'd1;
                  end else begin
                     ovf <= 1'b1;
                  end
                  // The tail itself may be the first overflowing word, so fold it in here.
                  if (in_pkt_data[133:132] == FLAG_TAIL) begin
                     out_valid_wr <= 1'b1;
                     out_valid    <= ~(DROP_EN & (ovf | (cnt >= MAX_CNT)));
                     state        <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (out_valid) begin
                  state <= S_WAIT_ID;
               end else begin
                  base  <= '0;
                  state <= S_IDLE;
               end
            end
            S_WAIT_ID: begin
               out_desc    <= {in_ID, cnt};
               out_desc_wr <= 1'b1;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef PKT_CACHE_WR_DROP_EN
   // Saturating count of packets reported as dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_drop_cnt <= '0;
      end else if (state == S_DONE && !out_valid && out_drop_cnt != 16'hFFFF) begin
         out_drop_cnt <= out_drop_cnt + 16'd1;
      end
   end
`else
   assign out_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_cache_wr.sv
// Testbench for pkt_cache_wr: table-driven packet cases, a mid-packet reset,
// randomized packets against a slot/length reference model, and back-to-back slots.
module tb_pkt_cache_wr;

   localparam int MAXW = 128;

   logic         clk = 1'b0;
   logic         rst;
   logic [133:0] in_pkt_data;
   logic         in_pkt_data_wr;
   logic         out_pkt_ready;
   logic [10:0]  in_waddr;
   logic         in_waddr_wr;
   logic         out_valid;
   logic         out_valid_wr;
   logic [7:0]   in_ID = 8'hEE;
   logic [133:0] out_ram_wdata;
   logic [10:0]  out_ram_waddr;
   logic         out_ram_wr;
   logic [15:0]  out_desc;
   logic         out_desc_wr;
   logic [15:0]  out_drop_cnt;

   pkt_cache_wr #(.MAX_WORDS(MAXW)) dut (
      .clk(clk), .rst(rst),
      .in_pkt_data(in_pkt_data), .in_pkt_data_wr(in_pkt_data_wr),
      .out_pkt_ready(out_pkt_ready),
      .in_waddr(in_waddr), .in_waddr_wr(in_waddr_wr),
      .out_valid(out_valid), .out_valid_wr(out_valid_wr),
      .in_ID(in_ID),
      .out_ram_wdata(out_ram_wdata), .out_ram_waddr(out_ram_waddr), .out_ram_wr(out_ram_wr),
      .out_desc(out_desc), .out_desc_wr(out_desc_wr),
      .out_drop_cnt(out_drop_cnt)
   );

   always #5 clk = ~clk;

   int           n_cmp = 0;
   int           n_bad = 0;
   int           n_rep = 0;
   int           exp_drops = 0;
   logic [10:0]  cur_base = '0;
   logic [10:0]  last_wr_addr = '0;
   logic [144:0] exp_wr[$];

   typedef struct {
      logic [10:0] base;
      int          n;
      bit          s_body;
      bit          s_waddr;
      logic        exp_v;
      logic [15:0] exp_d;
      logic [10:0] exp_last;
   } vec_t;

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: outcome of a packet from its slot and length alone.
   function automatic logic model_keep(input int n);
`ifdef PKT_CACHE_WR_DROP_EN
      return n <= MAXW;
`else
      return 1'b1;
`endif
   endfunction

   function automatic int model_len(input int n);
      return (n > MAXW) ? MAXW : n;
   endfunction

   function automatic logic [15:0] model_desc(input logic [10:0] b, input int n);
      return {4'h0, b[10:7], 8'(model_len(n))};
   endfunction

   function automatic logic [10:0] model_last(input logic [10:0] b, input int n);
      return {b[10:7], 7'(model_len(n) - 1)};
   endfunction

   function automatic logic [133:0] mk_word(input logic [1:0] f);
      return {f, 4'($urandom_range(1, 15)), $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Write scoreboard: every RAM write must be the next expected {addr, data}.
   always @(negedge clk) begin
      if (out_ram_wr) begin
         last_wr_addr = out_ram_waddr;
         if (exp_wr.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ram_write: got addr %0h expected no write", out_ram_waddr);
         end else begin
            chk("ram_write", {out_ram_waddr, out_ram_wdata}, exp_wr.pop_front());
         end
      end
      if (out_valid_wr) n_rep++;
   end

   // Address manager model: returns the slot number as ID one cycle after a keep report.
   always @(negedge clk) begin
      if (out_valid_wr && out_valid) begin
         logic [7:0] id_val;
         id_val = {4'h0, cur_base[10:7]};
         @(posedge clk); #1;
         in_ID = id_val;
         @(posedge clk); #1;
         in_ID = 8'hEE;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_pkt(input logic [10:0] b, input int n, input bit s_body, input bit s_waddr,
                           input bit gaps, input bit s_idle, input logic exp_v,
                           input logic [15:0] exp_d, input logic [10:0] exp_last);
      logic [133:0] w;
      logic [1:0]   f;
      cur_base = b;
      tick();
      in_waddr    = b;
      in_waddr_wr = 1'b1;
      tick();
      in_waddr_wr = 1'b0;
      in_waddr    = 11'($urandom);
      chk("ready_after_waddr", out_pkt_ready, 1'b1);
      if (s_body) begin
         in_pkt_data    = mk_word(2'b11);
         in_pkt_data_wr = 1'b1;
         tick();
         in_pkt_data_wr = 1'b0;
         chk("ready_after_body", out_pkt_ready, 1'b1);
         chk("no_write_on_body", out_ram_wr, 1'b0);
      end
      for (int i = 0; i < n; i++) begin
         if (gaps && i > 0) begin
            in_pkt_data_wr = 1'b0;
            in_waddr_wr    = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
         end
         f = (i == 0) ? 2'b01 : (i == n - 1) ? 2'b10 : 2'b11;
         w = mk_word(f);
         in_pkt_data    = w;
         in_pkt_data_wr = 1'b1;
         if (s_waddr && i == 1) begin
            in_waddr    = b ^ 11'h400;
            in_waddr_wr = 1'b1;
         end else begin
            in_waddr_wr = 1'b0;
         end
         if (i < MAXW) exp_wr.push_back({b[10:7], 7'(i), w});
         tick();
         if (i == 0) begin
            chk("head_write", out_ram_wr, 1'b1);
            chk("head_addr", out_ram_waddr, b);
            chk("ready_drop_on_head", out_pkt_ready, 1'b0);
         end
      end
      in_pkt_data_wr = 1'b0;
      in_waddr_wr    = 1'b0;
      chk("report_strobe", out_valid_wr, 1'b1);
      chk("report_valid", out_valid, exp_v);
      chk("tail_write", out_ram_wr, (n <= MAXW) ? 1'b1 : 1'b0);
      if (!exp_v) exp_drops++;
      if (s_idle) begin
         in_pkt_data    = mk_word(2'b01);
         in_pkt_data_wr = 1'b1;
      end
      tick();
      in_pkt_data_wr = 1'b0;
      chk("report_one_cycle", out_valid_wr, 1'b0);
      chk("last_addr", last_wr_addr, exp_last);
      chk("writes_drained", exp_wr.size(), 0);
      chk("drop_cnt", out_drop_cnt, 16'(exp_drops));
      tick();
      chk("desc_strobe", out_desc_wr, exp_v);
      if (exp_v) chk("desc_value", out_desc, exp_d);
   endtask

   vec_t vecs[6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{11'h180, 4,   1'b0, 1'b0, 1'b1, 16'h0304, 11'h183};
      vecs[1] = '{11'h780, 128, 1'b0, 1'b0, 1'b1, 16'h0F80, 11'h7FF};
`ifdef PKT_CACHE_WR_DROP_EN
      vecs[2] = '{11'h000, 130, 1'b0, 1'b0, 1'b0, 16'h0000, 11'h07F};
      vecs[4] = '{11'h080, 129, 1'b0, 1'b0, 1'b0, 16'h0000, 11'h0FF};
`else
      vecs[2] = '{11'h000, 130, 1'b0, 1'b0, 1'b1, 16'h0080, 11'h07F};
      vecs[4] = '{11'h080, 129, 1'b0, 1'b0, 1'b1, 16'h0180, 11'h0FF};
`endif
      vecs[3] = '{11'h200, 2,   1'b1, 1'b1, 1'b1, 16'h0402, 11'h201};
      vecs[5] = '{11'h100, 127, 1'b0, 1'b0, 1'b1, 16'h027F, 11'h17E};

      rst            = 1'b1;
      in_pkt_data    = '0;
      in_pkt_data_wr = 1'b0;
      in_waddr       = '0;
      in_waddr_wr    = 1'b0;
      repeat (2) tick();
      chk("rst_ready", out_pkt_ready, 1'b0);
      chk("rst_ram_wr", out_ram_wr, 1'b0);
      chk("rst_valid_wr", out_valid_wr, 1'b0);
      chk("rst_desc_wr", out_desc_wr, 1'b0);
      chk("rst_drop_cnt", out_drop_cnt, 16'h0);
      rst = 1'b0;
      tick();

      foreach (vecs[k])
         send_pkt(vecs[k].base, vecs[k].n, vecs[k].s_body, vecs[k].s_waddr, 1'b0, 1'b0,
                  vecs[k].exp_v, vecs[k].exp_d, vecs[k].exp_last);

      // Reset in the middle of a packet: no report, everything back to zero.
      begin
         int rep0;
         cur_base = 11'h300;
         tick();
         in_waddr    = 11'h300;
         in_waddr_wr = 1'b1;
         tick();
         in_waddr_wr = 1'b0;
         for (int i = 0; i < 3; i++) begin
            in_pkt_data    = mk_word((i == 0) ? 2'b01 : 2'b11);
            in_pkt_data_wr = 1'b1;
            exp_wr.push_back({4'h6, 7'(i), in_pkt_data});
            tick();
         end
         in_pkt_data_wr = 1'b0;
         rst  = 1'b1;
         rep0 = n_rep;
         tick();
         tick();
         chk("midrst_ram_wr", out_ram_wr, 1'b0);
         chk("midrst_ready", out_pkt_ready, 1'b0);
         chk("midrst_drop_cnt", out_drop_cnt, 16'h0);
         chk("midrst_ram_waddr", out_ram_waddr, 11'h0);
         rst       = 1'b0;
         exp_drops = 0;
         repeat (5) tick();
         chk("midrst_no_report", n_rep, rep0);
         chk("midrst_idle", out_pkt_ready, 1'b0);
      end

      for (int r = 0; r < 30; r++) begin
         logic [10:0] b;
         int          n;
         b = {4'($urandom_range(0, 15)), 7'd0};
         n = ($urandom_range(0, 3) == 0) ? $urandom_range(126, 134) : $urandom_range(2, 20);
         send_pkt(b, n, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  model_keep(n), model_desc(b, n), model_last(b, n));
      end

      for (int s = 0; s < 16; s++) begin
         logic [10:0] b;
         b = {4'(s), 7'd0};
         send_pkt(b, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {4'h0, 4'(s), 8'h02}, b + 11'd1);
      end

      repeat (3) tick();
      chk("final_no_pending_writes", exp_wr.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
